// File: rtl/wrr_egress_arbiter.sv
// Per-egress weighted round-robin packet arbiter: locks one ingress per packet,
// grants up to `weight` packets per turn, and exposes an Avalon-MM register slave.
module wrr_egress_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int IDX_WIDTH    = $clog2(N_PORTS),
  parameter int EGRESS_ID    = 0,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MAX_BEATS    = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [7:0]                     writedata,
  input  logic                           write,
  input  logic                           chipselect,
  input  logic [7:0]                     address,
  input  logic                           read,
  output logic [7:0]                     readdata,
  input  logic [N_PORTS-1:0]             ingress_valid,
  input  logic [N_PORTS-1:0]             ingress_last,
  input  logic [N_PORTS*IDX_WIDTH-1:0]   ingress_dst,
  input  logic                           egress_ready,
  output logic [IDX_WIDTH-1:0]           selected_ingress,
  output logic                           egress_valid,
  output logic                           egress_last,
  output logic [N_PORTS-1:0]             grant,
  output logic [N_PORTS-1:0]             ingress_ready
);

  localparam int BEAT_WIDTH = $clog2(MAX_BEATS + 1);
  localparam logic [IDX_WIDTH-1:0] EGRESS_SEL = IDX_WIDTH'(EGRESS_ID);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                    state_r;
  logic [IDX_WIDTH-1:0]      ptr_r, sel_r, prev_sel_r;
  logic [WEIGHT_WIDTH-1:0]   credit_r;
  logic [BEAT_WIDTH-1:0]     beat_cnt_r;
  logic [N_PORTS-1:0]        grant_r, enable_r;
  logic [WEIGHT_WIDTH-1:0]   weight_r [N_PORTS];
  logic                      wd_err_r;
  logic [7:0]                readdata_r;

  logic [N_PORTS-1:0]        req_s, onehot_s;
  logic [IDX_WIDTH-1:0]      winner_s, sel_next_s;
  logic                      found_s, beat_s, last_s, wd_fire_s, reg_wr_s, reg_rd_s;
  logic [WEIGHT_WIDTH-1:0]   eff_weight_s, credit_dec_s;
  logic [7:0]                rd_data_s;
  logic                      unused_s;

  // Index arithmetic modulo N_PORTS; base and offset are both below N_PORTS.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] base,
                                                     input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_PORTS) begin
      sum = sum - N_PORTS;
    end else begin
      sum = sum;
    end
    return sum[IDX_WIDTH-1:0];
  endfunction

  assign beat_s       = (state_r == LOCK) & ingress_valid[sel_r] & egress_ready;
  assign last_s       = beat_s & ingress_last[sel_r];
  assign wd_fire_s    = beat_s & ~ingress_last[sel_r] &
                        (beat_cnt_r + BEAT_WIDTH'(1) == BEAT_WIDTH'(MAX_BEATS));
  assign credit_dec_s = credit_r - WEIGHT_WIDTH'(1);
  assign sel_next_s   = wrap_inc(sel_r, 1);
  assign onehot_s     = {{(N_PORTS-1){1'b0}}, 1'b1} << winner_s;
  assign reg_wr_s     = chipselect & write;
  assign reg_rd_s     = chipselect & read;
  assign unused_s     = ^writedata;

  // Request qualification and rotating-priority winner search from ptr
  always_comb begin
    req_s        = '0;
    winner_s     = '0;
    found_s      = 1'b0;
    eff_weight_s = WEIGHT_WIDTH'(1);
    for (int i = 0; i < N_PORTS; i++) begin
      req_s[i] = ingress_valid[i] & (ingress_dst[i*IDX_WIDTH +: IDX_WIDTH] == EGRESS_SEL) &
                 enable_r[i];
    end
    // Descending scan so the port closest to ptr is the last one written.
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req_s[wrap_inc(ptr_r, k)]) begin
        winner_s = wrap_inc(ptr_r, k);
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
        found_s  = found_s;
      end
    end
    if (weight_r[winner_s] == '0) begin
      eff_weight_s = WEIGHT_WIDTH'(1);
    end else begin
      eff_weight_s = weight_r[winner_s];
    end
  end

  // Arbitration FSM: packet lock, credit accounting and beat watchdog
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      sel_r      <= '0;
      prev_sel_r <= '0;
      credit_r   <= '0;
      beat_cnt_r <= '0;
      grant_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r    <= LOCK;
            sel_r      <= winner_s;
            grant_r    <= onehot_s;
            beat_cnt_r <= '0;
            if (winner_s != prev_sel_r || credit_r == '0) begin
              credit_r <= eff_weight_s;
            end
          end
        end
        LOCK: begin
          if (last_s) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            beat_cnt_r <= '0;
            credit_r   <= credit_dec_s;
            prev_sel_r <= sel_r;
            ptr_r      <= (credit_dec_s != '0) ? sel_r : sel_next_s;
          end else if (wd_fire_s) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            beat_cnt_r <= '0;
            credit_r   <= '0;
            ptr_r      <= sel_next_s;
          end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_WIDTH'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Register read mux; unmapped addresses read as zero
  always_comb begin
    rd_data_s = 8'h00;
    if (address == 8'h00) begin
      rd_data_s = 8'(enable_r);
    end else if (address == 8'h10) begin
      rd_data_s = {6'b000000, wd_err_r, state_r == LOCK};
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (address == 8'(i + 1)) begin
          rd_data_s = 8'(weight_r[i]);
        end else begin
          rd_data_s = rd_data_s;
        end
      end
    end
  end

  // Configuration registers, sticky watchdog flag and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_r   <= '1;
      wd_err_r   <= 1'b0;
      readdata_r <= 8'h00;
      for (int i = 0; i < N_PORTS; i++) begin
        weight_r[i] <= WEIGHT_WIDTH'(1);
      end
    end else begin
      if (reg_wr_s && address == 8'h00) begin
        enable_r <= writedata[N_PORTS-1:0];
      end
      for (int i = 0; i < N_PORTS; i++) begin
        if (reg_wr_s && address == 8'(i + 1)) begin
          weight_r[i] <= writedata[WEIGHT_WIDTH-1:0];
        end
      end
      if (wd_fire_s) begin
        wd_err_r <= 1'b1;
      end else if (reg_wr_s && address == 8'h10 && writedata[1]) begin
        wd_err_r <= 1'b0;
      end
      if (reg_rd_s) begin
        readdata_r <= rd_data_s;
      end
    end
  end

  assign readdata         = readdata_r;
  assign grant            = grant_r;
  assign selected_ingress = sel_r;
  assign egress_valid     = (state_r == LOCK) & ingress_valid[sel_r];
  assign egress_last      = (state_r == LOCK) & ingress_last[sel_r];
  assign ingress_ready    = (state_r == LOCK) ? (grant_r & {N_PORTS{egress_ready}}) : '0;

endmodule
